// File: rtl/apb_mm_regs.sv
// APB register front-end for the matrix-multiplier core: control/status registers
// plus operand and result FIFOs, with bounded pready stalling on FIFO full/empty.
module apb_mm_regs #(
    parameter int FIFO_DEPTH = 8,
    parameter int WAIT_MAX   = 16
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic [2:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [15:0] pwdata,
    output logic        pready,
    output logic [15:0] prdata,
    output logic        start,
    output logic [11:0] dim,
    input  logic        core_busy,
    input  logic        core_done,
    output logic        in_valid,
    output logic [15:0] in_data,
    input  logic        in_ready,
    input  logic        out_valid,
    input  logic [15:0] out_data,
    output logic        out_ready,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_DIM    = 3'd2;
    localparam logic [2:0] A_IN     = 3'd3;
    localparam logic [2:0] A_OUT    = 3'd4;
    localparam logic [2:0] A_IRQEN  = 3'd5;

    logic [15:0]   in_mem_q  [FIFO_DEPTH];
    logic [15:0]   in_mem_d  [FIFO_DEPTH];
    logic [15:0]   out_mem_q [FIFO_DEPTH];
    logic [15:0]   out_mem_d [FIFO_DEPTH];
    logic [AW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [LW-1:0] in_lvl_q, in_lvl_d, out_lvl_q, out_lvl_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [11:0]   dim_q, dim_d;
    logic          irq_en_q, irq_en_d;
    logic          done_q, done_d;
    logic          terr_q, terr_d;
    logic          start_q, start_d;
    logic          irq_q, irq_d;

    logic        access, commit, wr_commit, stall, timed_out, to_evt, w1c;
    logic        in_full, in_empty, out_full, out_empty;
    logic        in_push, in_pop, out_push, out_pop, soft_clr;
    logic [15:0] status;

    // Core-side handshakes are plain valid/ready: a word moves on any edge where
    // both are high; in_valid/out_ready depend only on registered FIFO levels.
    assign in_full   = (in_lvl_q == LW'(FIFO_DEPTH));
    assign in_empty  = (in_lvl_q == '0);
    assign out_full  = (out_lvl_q == LW'(FIFO_DEPTH));
    assign out_empty = (out_lvl_q == '0);
    assign in_valid  = ~in_empty;
    assign in_data   = in_mem_q[in_rd_q];
    assign out_ready = ~out_full;
    assign start     = start_q;
    assign dim       = dim_q;
    assign irq       = irq_q;
    assign status    = {11'b0, terr_q, out_empty, in_full, done_q, core_busy};

    always_comb begin
        access    = psel & penable;
        stall     = access & ((pwrite & (paddr == A_IN) & in_full) |
                              (~pwrite & (paddr == A_OUT) & out_empty));
        timed_out = (wait_q == CW'(WAIT_MAX));
        pready    = ~(stall & ~timed_out);
        commit    = access & pready;
        to_evt    = commit & stall;
        wr_commit = commit & pwrite;
        w1c       = wr_commit & (paddr == A_STATUS);

        prdata = '0;
        if (access & ~pwrite) begin
            case (paddr)
                A_STATUS: prdata = status;
                A_DIM:    prdata = {4'b0, dim_q};
                A_OUT:    prdata = out_empty ? 16'hDEAD : out_mem_q[out_rd_q];
                A_IRQEN:  prdata = {15'b0, irq_en_q};
                default:  prdata = '0;
            endcase
        end
    end

    always_comb begin
        in_push  = wr_commit & (paddr == A_IN) & ~in_full;
        in_pop   = ~in_empty & in_ready;
        out_push = out_valid & ~out_full;
        out_pop  = commit & ~pwrite & (paddr == A_OUT) & ~out_empty;
        soft_clr = wr_commit & (paddr == A_CTRL) & pwdata[1];

        in_mem_d = in_mem_q;
        if (in_push) in_mem_d[in_wr_q] = pwdata;
        in_wr_d  = in_wr_q + AW'(in_push);
        in_rd_d  = in_rd_q + AW'(in_pop);
        in_lvl_d = in_lvl_q + LW'(in_push) - LW'(in_pop);

        out_mem_d = out_mem_q;
        if (out_push) out_mem_d[out_wr_q] = out_data;
        out_wr_d  = out_wr_q + AW'(out_push);
        out_rd_d  = out_rd_q + AW'(out_pop);
        out_lvl_d = out_lvl_q + LW'(out_push) - LW'(out_pop);

        // Clear overrides any push/pop landing on the same edge.
        if (soft_clr) begin
            in_wr_d   = '0;
            in_rd_d   = '0;
            in_lvl_d  = '0;
            out_wr_d  = '0;
            out_rd_d  = '0;
            out_lvl_d = '0;
        end
    end

    always_comb begin
        wait_d   = commit ? '0 : (access ? wait_q + CW'(1) : wait_q);
        dim_d    = (wr_commit & (paddr == A_DIM)) ? pwdata[11:0] : dim_q;
        irq_en_d = (wr_commit & (paddr == A_IRQEN)) ? pwdata[0] : irq_en_q;
        start_d  = wr_commit & (paddr == A_CTRL) & pwdata[0];
        done_d   = core_done | (done_q & ~(w1c & pwdata[1]));
        terr_d   = to_evt | (terr_q & ~(w1c & pwdata[4]));
        irq_d    = done_q & irq_en_q;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                in_mem_q[i]  <= '0;
                out_mem_q[i] <= '0;
            end
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_lvl_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_lvl_q <= '0;
            wait_q    <= '0;
            dim_q     <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            in_mem_q  <= in_mem_d;
            out_mem_q <= out_mem_d;
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_lvl_q  <= in_lvl_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_lvl_q <= out_lvl_d;
            wait_q    <= wait_d;
            dim_q     <= dim_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_apb_mm_regs.sv
// Directed bench for apb_mm_regs: queue-based register/FIFO model checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_apb_mm_regs;
    localparam int DEPTH = 8;
    localparam int WMAX  = 16;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic [2:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] pwdata = '0;
    logic        pready;
    logic [15:0] prdata;
    logic        start;
    logic [11:0] dim;
    logic        core_busy = 1'b0, core_done = 1'b0;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready = 1'b0;
    logic        out_valid = 1'b0;
    logic [15:0] out_data = '0;
    logic        out_ready;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    apb_mm_regs #(.FIFO_DEPTH(DEPTH), .WAIT_MAX(WMAX)) dut (
        .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
        .prdata(prdata), .start(start), .dim(dim), .core_busy(core_busy),
        .core_done(core_done), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .irq(irq)
    );

    initial forever #5 pclk = ~pclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_in_q[$];
    logic [15:0] m_out_q[$];
    logic [11:0] m_dim = '0;
    logic m_irq_en = 0, m_done = 0, m_terr = 0, m_start = 0, m_irq = 0;
    int   m_wait = 0;

    function automatic bit m_stall();
        if (!(psel && penable)) return 0;
        if (pwrite && paddr == 3 && m_in_q.size() == DEPTH) return 1;
        if (!pwrite && paddr == 4 && m_out_q.size() == 0) return 1;
        return 0;
    endfunction

    function automatic bit m_pready();
        return !(m_stall() && m_wait < WMAX);
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s = '0;
        s[0] = core_busy;
        s[1] = m_done;
        s[2] = (m_in_q.size() == DEPTH);
        s[3] = (m_out_q.size() == 0);
        s[4] = m_terr;
        return s;
    endfunction

    function automatic logic [15:0] m_prdata();
        if (!(psel && penable) || pwrite) return 16'h0000;
        case (paddr)
            3'd1: return m_status();
            3'd2: return {4'b0, m_dim};
            3'd4: return (m_out_q.size() == 0) ? 16'hDEAD : m_out_q[0];
            3'd5: return {15'b0, m_irq_en};
            default: return 16'h0000;
        endcase
    endfunction

    bit acc, com, to, cpop, cpush, bpush, bpop, clr, w1c;
    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            m_in_q.delete();
            m_out_q.delete();
            m_dim = '0; m_irq_en = 0; m_done = 0; m_terr = 0;
            m_start = 0; m_irq = 0; m_wait = 0;
        end else begin
            acc   = psel && penable;
            com   = acc && m_pready();
            to    = com && m_stall();
            cpop  = (m_in_q.size() != 0) && in_ready;
            cpush = out_valid && (m_out_q.size() < DEPTH);
            bpush = com && pwrite && paddr == 3 && !to;
            bpop  = com && !pwrite && paddr == 4 && !to;
            clr   = com && pwrite && paddr == 0 && pwdata[1];
            w1c   = com && pwrite && paddr == 1;
            m_irq   = m_done && m_irq_en;
            m_start = com && pwrite && paddr == 0 && pwdata[0];
            m_done  = core_done || (m_done && !(w1c && pwdata[1]));
            m_terr  = to || (m_terr && !(w1c && pwdata[4]));
            if (com && pwrite && paddr == 2) m_dim = pwdata[11:0];
            if (com && pwrite && paddr == 5) m_irq_en = pwdata[0];
            if (cpop) void'(m_in_q.pop_front());
            if (bpush) m_in_q.push_back(pwdata);
            if (bpop) void'(m_out_q.pop_front());
            if (cpush) m_out_q.push_back(out_data);
            if (clr) begin m_in_q.delete(); m_out_q.delete(); end
            m_wait = com ? 0 : (acc ? m_wait + 1 : m_wait);
        end
    end

    // ---------------- per-cycle compare ----------------
    bit exp_rdy;
    always @(negedge pclk) begin
        exp_rdy = m_pready();
        check("pready", {15'b0, pready}, {15'b0, exp_rdy});
        if (!(psel && penable) || exp_rdy) check("prdata", prdata, m_prdata());
        check("start", {15'b0, start}, {15'b0, m_start});
        check("dim", {4'b0, dim}, {4'b0, m_dim});
        check("irq", {15'b0, irq}, {15'b0, m_irq});
        check("in_valid", {15'b0, in_valid}, {15'b0, m_in_q.size() != 0});
        if (m_in_q.size() != 0) check("in_data", in_data, m_in_q[0]);
        check("out_ready", {15'b0, out_ready}, {15'b0, m_out_q.size() < DEPTH});
    end

    // ---------------- driver ----------------
    task automatic apb_xfer(input logic w, input logic [2:0] a, input logic [15:0] d,
                            output logic [15:0] rd, output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (!pready && waits < 100) begin
            waits++;
            @(negedge pclk);
        end
        if (!pready) begin
            n_checks++; n_fail++;
            $display("FAIL bus_wait: pready still 0 after %0d cycles", waits);
        end
        rd = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [15:0] rd;
    int w;

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", {15'b0, pready}, 16'h1);
        check("rst_prdata", prdata, 16'h0);
        check("rst_start_irq", {14'b0, start, irq}, 16'h0);
        check("rst_in_valid", {15'b0, in_valid}, 16'h0);
        check("rst_out_ready", {15'b0, out_ready}, 16'h1);
        preset_n = 1'b1;
        @(posedge pclk); #1;

        // DIM read/write, zero wait
        apb_xfer(1, 3'd2, 16'h0234, rd, w);
        check("dim_wr_wait", 16'(w), 16'd0);
        apb_xfer(0, 3'd2, 16'h0, rd, w);
        check("dim_rd", rd, 16'h0234);
        check("dim_rd_wait", 16'(w), 16'd0);
        check("dim_out", {4'b0, dim}, 16'h0234);
        apb_xfer(1, 3'd6, 16'hFFFF, rd, w);
        apb_xfer(0, 3'd6, 16'h0, rd, w);
        check("rsvd_rd", rd, 16'h0);

        // Fill input FIFO, then time out on the 9th write
        for (int i = 1; i <= 8; i++) begin
            apb_xfer(1, 3'd3, 16'(i), rd, w);
            check("in_wr_wait", 16'(w), 16'd0);
        end
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("status_full", rd, 16'h000C);
        apb_xfer(1, 3'd3, 16'h0009, rd, w);
        check("in_timeout_wait", 16'(w), 16'd16);
        core_busy = 1'b1;
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("status_terr", rd, 16'h001D);
        core_busy = 1'b0;
        check("in_head", in_data, 16'h0001);
        in_ready = 1'b1;
        @(posedge pclk); #1;
        in_ready = 1'b0;
        check("in_head2", in_data, 16'h0002);
        in_ready = 1'b1;
        repeat (7) @(posedge pclk);
        #1;
        in_ready = 1'b0;
        check("in_drained", {15'b0, in_valid}, 16'h0);
        apb_xfer(1, 3'd1, 16'h0010, rd, w);
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("status_terr_clr", rd, 16'h0008);

        // Output read stalled until the core pushes
        fork
            apb_xfer(0, 3'd4, 16'h0, rd, w);
            begin
                repeat (3) @(posedge pclk);
                #1; out_valid = 1'b1; out_data = 16'hBEEF;
                @(posedge pclk); #1; out_valid = 1'b0;
            end
        join
        check("out_rd", rd, 16'hBEEF);
        check("out_rd_wait", 16'(w), 16'd3);
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("status_out_empty", rd, 16'h0008);
        apb_xfer(0, 3'd4, 16'h0, rd, w);
        check("out_timeout_rd", rd, 16'hDEAD);
        check("out_timeout_wait", 16'(w), 16'd16);
        apb_xfer(1, 3'd1, 16'h0010, rd, w);

        // done / irq
        apb_xfer(1, 3'd5, 16'h0001, rd, w);
        apb_xfer(0, 3'd5, 16'h0, rd, w);
        check("irq_en_rd", rd, 16'h0001);
        core_done = 1'b1;
        @(posedge pclk); #1;
        core_done = 1'b0;
        @(negedge pclk);
        check("irq_lag", {15'b0, irq}, 16'h0);
        @(negedge pclk);
        check("irq_set", {15'b0, irq}, 16'h1);
        @(posedge pclk); #1;
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("status_done", rd, 16'h000A);
        apb_xfer(1, 3'd1, 16'h0002, rd, w);
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("status_done_clr", rd, 16'h0008);
        check("irq_clr", {15'b0, irq}, 16'h0);
        fork
            apb_xfer(1, 3'd1, 16'h0002, rd, w);
            begin
                @(posedge pclk); #1; core_done = 1'b1;
                @(posedge pclk); #1; core_done = 1'b0;
            end
        join
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("done_beats_w1c", rd, 16'h000A);
        apb_xfer(1, 3'd1, 16'h0002, rd, w);

        // START pulse and soft clear
        apb_xfer(1, 3'd0, 16'h0001, rd, w);
        @(negedge pclk);
        check("start_hi", {15'b0, start}, 16'h1);
        @(negedge pclk);
        check("start_lo", {15'b0, start}, 16'h0);
        @(posedge pclk); #1;
        for (int i = 0; i < 5; i++) apb_xfer(1, 3'd3, 16'(16'h00A0 + i), rd, w);
        check("pre_clr_valid", {15'b0, in_valid}, 16'h1);
        fork
            apb_xfer(1, 3'd0, 16'h0002, rd, w);
            begin
                @(posedge pclk); #1; in_ready = 1'b1;
                @(posedge pclk); #1; in_ready = 1'b0;
            end
        join
        @(negedge pclk);
        check("soft_clr_valid", {15'b0, in_valid}, 16'h0);
        @(posedge pclk); #1;
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("soft_clr_status", rd, 16'h0008);

        // Reset in the middle of a stalled write
        for (int i = 0; i < 8; i++) apb_xfer(1, 3'd3, 16'(16'h0100 + i), rd, w);
        out_valid = 1'b1; out_data = 16'h5A5A;
        @(posedge pclk); #1; out_valid = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd3; pwdata = 16'h0077;
        @(posedge pclk); #1; penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check("stall_before_rst", {15'b0, pready}, 16'h0);
        #2 preset_n = 1'b0;
        #1;
        check("rst_mid_pready", {15'b0, pready}, 16'h1);
        check("rst_mid_in_valid", {15'b0, in_valid}, 16'h0);
        check("rst_mid_out_ready", {15'b0, out_ready}, 16'h1);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        apb_xfer(0, 3'd1, 16'h0, rd, w);
        check("rst_status", rd, 16'h0008);
        apb_xfer(0, 3'd2, 16'h0, rd, w);
        check("rst_dim", rd, 16'h0000);
        apb_xfer(0, 3'd5, 16'h0, rd, w);
        check("rst_irq_en", rd, 16'h0000);

        repeat (3) @(posedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_mm_regs.md
Name: apb_mm_regs

Overview:
- APB slave stage that consumes transfers from the 3-bit-address, 16-bit-data APB interface.
- Exposes the matrix-multiplier control/status registers to the bus.
- Buffers operand words into an input FIFO feeding the compute core, and result words from the core into an output FIFO read over APB.
- Stalls the bus with pready while a FIFO cannot accept or supply data, bounded by a timeout.

Parameters:
FIFO_DEPTH, 8, entries per FIFO (power of two, >=2)
WAIT_MAX, 16, max wait cycles in one access phase before forced completion

Ports:
pclk  in  1  bus/core clock
preset_n  in  1  reset, asynchronous, active-low
paddr  in  3  register address
psel  in  1  slave select
penable  in  1  access phase
pwrite  in  1  1=write, 0=read
pwdata  in  16  write data
pready  out  1  transfer complete
prdata  out  16  read data
start  out  1  one-cycle start pulse to core
dim  out  12  {P[11:8],N[7:4],M[3:0]} to core
core_busy  in  1  core computing
core_done  in  1  one-cycle completion pulse
in_valid  out  1  input FIFO not empty
in_data  out  16  input FIFO head
in_ready  in  1  core pops input word
out_valid  in  1  core pushes result word
out_data  in  16  result word
out_ready  out  1  output FIFO not full
irq  out  1  done & irq_en

Behaviour:
- Reset (preset_n=0, async):
  - FIFOs empty; all registers 0.
  - pready=1, prdata=0, start=0, dim=0, irq=0, in_valid=0, out_ready=1.
  - Wait counter 0.
  - Reset mid-transfer aborts it; the master restarts after reset.
- Phases:
  - setup = psel&!penable; access = psel&penable.
  - Outside access, pready=1 and prdata=0.
  - pready and prdata are combinational from registered state during access.
  - A transfer commits at the posedge where access&pready.
- Register map:
  - 0 CTRL:
    - W bit0=START: start=1 for the cycle after commit.
    - W bit1=SOFT_CLR: empties both FIFOs next edge.
    - Reads 0.
  - 1 STATUS (RO except W1C):
    - [0] core_busy
    - [1] done, sticky: set by core_done; W1C
    - [2] in_full
    - [3] out_empty
    - [4] timeout_err, sticky: W1C
    - [15:5] 0
  - 2 DIM: RW [11:0], [15:12] read 0.
  - 3 IN_DATA:
    - Write pushes pwdata.
    - pready = !in_full | timeout.
    - Read returns 0 with zero wait.
  - 4 OUT_DATA:
    - Read pops the head; prdata = head.
    - pready = !out_empty | timeout.
    - Write ignored, zero wait.
  - 5 IRQ_EN: RW bit0.
  - 6, 7: reserved; read 0, writes ignored, zero wait.
- Zero-wait registers: pready=1 in the first access cycle.
- Timeout:
  - Wait counter increments each access cycle with pready=0 and clears on commit.
  - When counter==WAIT_MAX, pready=1 that cycle.
  - Write is dropped; read returns 16'hDEAD with no pop; timeout_err set.
- FIFOs:
  - Circular pointers with wrap at FIFO_DEPTH; level counter 0..FIFO_DEPTH.
  - Push only when not full and pop only when not empty.
  - No same-cycle pass-through: a push into an empty FIFO is visible next cycle.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the level.
  - Core pop when in_valid&in_ready; core push when out_valid&out_ready.
- Priority:
  - SOFT_CLR beats a concurrent push or pop.
  - core_done beats a same-cycle W1C of done (done stays 1).
  - timeout_err set beats W1C.
- irq is registered: irq = done & irq_en, updating one cycle after either changes.
- START while core_busy=1 still pulses; the core ignores it.

Test Plan:
- Write DIM=0x0234 (setup+access, 2 cycles), read DIM -> prdata=0x0234, pready=1 in first access cycle; dim=0x234.
- 8 writes to IN_DATA 0x0001..0x0008 with in_ready=0 -> each zero-wait, STATUS[2]=1. 9th write holds pready=0 for 16 cycles, then pready=1, word dropped, STATUS[4]=1. Pulse in_ready once -> in_data sequence starts at 0x0001.
- Read OUT_DATA on empty FIFO; core pushes 0xBEEF after 3 wait cycles -> pready rises the cycle after the push, prdata=0xBEEF, STATUS[3]=1 afterwards.
- IRQ_EN=1, pulse core_done -> STATUS[1]=1, irq=1 next cycle. Write STATUS=0x0002 -> done=0, irq=0. Repeat with core_done coincident with the W1C commit -> done stays 1.
- Write CTRL=0x0001 -> start high exactly one cycle. Write CTRL=0x0002 with 5 words queued and in_ready=1 same cycle -> level 0, in_valid=0 next cycle.
- Assert preset_n=0 mid-access of a stalled IN_DATA write -> pready=1, FIFOs empty, STATUS reads 0x0008 after release.
